mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: RAM byte port plus fetch and load/store request bundles.
// slave = arbiter side, master = requesters/RAM side.
interface mem_arbiter_if;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_data;

  logic        ls_req;
  logic        ls_wr;
  logic [31:0] ls_addr;
  logic [1:0]  ls_size;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  modport slave (
    input  mem_din, io_buffer_full,
    input  ic_req, ic_addr,
    input  ls_req, ls_wr, ls_addr,
    input  ls_size, ls_wdata,
    output mem_dout, mem_a, mem_wr,
    output ic_done, ic_data,
    output ls_done, ls_rdata
  );

  modport master (
    output mem_din, io_buffer_full,
    output ic_req, ic_addr,
    output ls_req, ls_wr, ls_addr,
    output ls_size, ls_wdata,
    input  mem_dout, mem_a, mem_wr,
    input  ic_done, ic_data,
    input  ls_done, ls_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin byte RAM arbiter for fetch and load/store.
// MEM_ARB_IO_STALL_EN: hold off UART-space writes while io_buffer_full.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_LS = 1'b1;

  state_t      state_q, state_d;
  logic        owner_q, last_q;
  logic [1:0]  cnt_q, left_q, len_q, pipe_q;
  logic [31:0] a_q, wdata_q;
  logic [31:0] ic_data_q, ls_rdata_q;
  logic [7:0]  dout_q;
  logic        wr_q, ic_done_q, ls_done_q;

  logic        io_block, ls_ok;
  logic        gnt_ls, gnt_ic;
  logic        own_req, fin_rd;
  logic [1:0]  ls_len;
  logic [4:0]  bsel;

`ifdef MEM_ARB_IO_STALL_EN
  assign io_block = bus.ls_wr
                 && bus.ls_addr[17:16] == 2'b11
                 && bus.io_buffer_full;
`else
  logic unused_io;
  assign unused_io = bus.io_buffer_full;
  assign io_block  = 1'b0;
`endif

  assign bsel = {cnt_q, 3'b000};

  always_comb begin
    ls_ok   = bus.ls_req && !io_block;
    gnt_ls  = ls_ok
           && (!bus.ic_req || last_q == OWN_IC);
    gnt_ic  = bus.ic_req && !gnt_ls;
    own_req = (owner_q == OWN_LS) ? bus.ls_req
                                  : bus.ic_req;
    // pipe_q[1]: a byte addressed two edges ago lands now
    fin_rd  = pipe_q[1] && cnt_q == len_q;
    unique case (1'b1)
      bus.ls_size == 2'd0: ls_len = 2'd0;
      bus.ls_size == 2'd1: ls_len = 2'd1;
      default:             ls_len = 2'd3;
    endcase
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_ls)
          state_d = bus.ls_wr ? WR : RD;
        else if (gnt_ic)
          state_d = RD;
      end
      RD: begin
        if (!own_req || fin_rd)
          state_d = IDLE;
      end
      WR: begin
        if (left_q == 2'd0)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IC;
      last_q     <= OWN_IC;
      cnt_q      <= '0;
      left_q     <= '0;
      len_q      <= '0;
      pipe_q     <= '0;
      a_q        <= '0;
      wdata_q    <= '0;
      ic_data_q  <= '0;
      ls_rdata_q <= '0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      ic_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else if (rdy) begin
      state_q   <= state_d;
      ic_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_ls || gnt_ic) begin
            owner_q <= gnt_ls;
            last_q  <= gnt_ls;
            a_q     <= gnt_ls ? bus.ls_addr
                              : bus.ic_addr;
            len_q   <= gnt_ls ? ls_len : 2'd3;
            left_q  <= gnt_ls ? ls_len : 2'd3;
            cnt_q   <= 2'd0;
            pipe_q  <= 2'b01;
            if (gnt_ls && bus.ls_wr) begin
              wdata_q <= bus.ls_wdata;
              dout_q  <= bus.ls_wdata[7:0];
              wr_q    <= 1'b1;
              cnt_q   <= 2'd1;
              pipe_q  <= 2'b00;
            end else if (gnt_ls) begin
              ls_rdata_q <= '0;
            end else begin
              ic_data_q <= '0;
            end
          end
        end
        RD: begin
          if (!own_req) begin
            pipe_q <= 2'b00;
          end else begin
            if (pipe_q[1]) begin
              if (owner_q == OWN_LS)
                ls_rdata_q[bsel +: 8] <= bus.mem_din;
              else
                ic_data_q[bsel +: 8] <= bus.mem_din;
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == len_q) begin
                ls_done_q <= owner_q == OWN_LS;
                ic_done_q <= owner_q == OWN_IC;
              end
            end
            pipe_q <= {pipe_q[0], left_q != 2'd0};
            if (left_q != 2'd0) begin
              a_q    <= a_q + 32'd1;
              left_q <= left_q - 2'd1;
            end
          end
        end
        WR: begin
          if (left_q != 2'd0) begin
            a_q    <= a_q + 32'd1;
            dout_q <= wdata_q[bsel +: 8];
            cnt_q  <= cnt_q + 2'd1;
            left_q <= left_q - 2'd1;
          end else begin
            wr_q      <= 1'b0;
            ls_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_a    = a_q;
  assign bus.mem_dout = dout_q;
  assign bus.mem_wr   = wr_q;
  assign bus.ic_done  = ic_done_q;
  assign bus.ic_data  = ic_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;
endmodule
